// File: rtl/dsp_mac_sequencer_if.sv
// rtl/dsp_mac_sequencer_if.sv - operand input stream and result output stream of the MAC sequencer
interface dsp_mac_sequencer_if #(
  parameter int DW    = 18,
  parameter int PW    = 48,
  parameter int LEN_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_a;
  logic [DW-1:0]    in_b;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [PW-1:0]    out_p;
  logic [LEN_W-1:0] out_count;

  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_p, out_count
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_p, out_count
  );
endinterface

// File: rtl/dsp_mac_sequencer.sv
// rtl/dsp_mac_sequencer.sv - drives a DSP48A1-style slice to accumulate one dot product per operand vector
// Define DSP_MAC_OVF_EN to add the sticky carry flag out_ovf captured with each result.
module dsp_mac_sequencer #(
  parameter int DW       = 18,
  parameter int PW       = 48,
  parameter int LEN_W    = 8,
  parameter int PIPE_LAT = 3,
  parameter int OPM_SKEW = 1
) (
  input  logic               CLK,
  input  logic               RST,
  dsp_mac_sequencer_if.slave s_if,
  output logic [DW-1:0]      DSP_A,
  output logic [DW-1:0]      DSP_B,
  output logic [7:0]         DSP_OPMODE,
  input  logic [PW-1:0]      DSP_P,
  input  logic               DSP_CARRYOUT
`ifdef DSP_MAC_OVF_EN
  ,
  output logic               out_ovf
`endif
);

  localparam logic [7:0] OPM_FIRST = 8'h01;
  localparam logic [7:0] OPM_ACC   = 8'h09;
  localparam logic [7:0] OPM_HOLD  = 8'h08;
  localparam int         DRN_W     = (PIPE_LAT < 2) ? 1 : $clog2(PIPE_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [PW-1:0]    r_out_p;
  logic [LEN_W-1:0] r_count;
  logic [LEN_W-1:0] r_out_count;
  logic [DRN_W-1:0] r_drain;
  logic [DW-1:0]    r_dsp_a;
  logic [DW-1:0]    r_dsp_b;
  logic [7:0]       r_opmode;
  logic [1:0]       r_tag [OPM_SKEW];

  logic             w_accept;
  logic             w_first;
  logic             w_capture;
  logic [7:0]       w_opm_next;

  assign w_accept  = s_if.in_valid & r_in_ready;
  assign w_first   = (r_state == S_IDLE);
  assign w_capture = (r_state == S_DRAIN) && (r_drain == DRN_W'(PIPE_LAT));

  // Tag {valid, first} lines up with the slice post-adder; no tag means P holds.
  always_comb begin
    w_opm_next = OPM_HOLD;
    if (r_tag[OPM_SKEW-1][1]) begin
      w_opm_next = r_tag[OPM_SKEW-1][0] ? OPM_FIRST : OPM_ACC;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_p     <= '0;
      r_count     <= '0;
      r_out_count <= '0;
      r_drain     <= '0;
      r_dsp_a     <= '0;
      r_dsp_b     <= '0;
      r_opmode    <= OPM_HOLD;
      for (int k = 0; k < OPM_SKEW; k++) begin
        r_tag[k] <= 2'b00;
      end
    end else begin
      r_tag[0] <= {w_accept, w_first};
      for (int k = 1; k < OPM_SKEW; k++) begin
        r_tag[k] <= r_tag[k-1];
      end
      r_opmode <= w_opm_next;
      if (w_accept) begin
        r_dsp_a <= s_if.in_a;
        r_dsp_b <= s_if.in_b;
      end

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_count <= LEN_W'(1);
            if (s_if.in_last) begin
              r_state    <= S_DRAIN;
              r_in_ready <= 1'b0;
              r_drain    <= '0;
            end else begin
              r_state <= S_ACCUM;
            end
          end
        end
        S_ACCUM: begin
          if (w_accept) begin
            if (r_count != {LEN_W{1'b1}}) begin
              r_count <= r_count + LEN_W'(1);
            end
            if (s_if.in_last) begin
              r_state    <= S_DRAIN;
              r_in_ready <= 1'b0;
              r_drain    <= '0;
            end
          end
        end
        // Extra cycle past PIPE_LAT so the last beat's P update is visible at capture.
        S_DRAIN: begin
          if (w_capture) begin
            r_out_p     <= DSP_P;
            r_out_count <= r_count;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_drain <= r_drain + DRN_W'(1);
          end
        end
        S_DONE: begin
          if (s_if.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign s_if.in_ready  = r_in_ready;
  assign s_if.out_valid = r_out_valid;
  assign s_if.out_p     = r_out_p;
  assign s_if.out_count = r_out_count;
  assign DSP_A          = r_dsp_a;
  assign DSP_B          = r_dsp_b;
  assign DSP_OPMODE     = r_opmode;

`ifdef DSP_MAC_OVF_EN
  logic [PIPE_LAT:0] r_cy_pipe;
  logic              r_ovf_acc;
  logic              r_out_ovf;
  logic              w_cy_hit;

  // Carry for a beat appears in the slice CARRYOUT register PIPE_LAT+1 edges after acceptance.
  assign w_cy_hit = r_cy_pipe[PIPE_LAT] & DSP_CARRYOUT;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cy_pipe <= '0;
      r_ovf_acc <= 1'b0;
      r_out_ovf <= 1'b0;
    end else begin
      r_cy_pipe <= {r_cy_pipe[PIPE_LAT-1:0], w_accept};
      if (w_accept && w_first) begin
        r_ovf_acc <= 1'b0;
      end else begin
        r_ovf_acc <= r_ovf_acc | w_cy_hit;
      end
      if (w_capture) begin
        r_out_ovf <= r_ovf_acc | w_cy_hit;
      end
    end
  end

  assign out_ovf = r_out_ovf;
`else
  logic w_unused_carry;
  assign w_unused_carry = DSP_CARRYOUT;
`endif

endmodule
